// File: rtl/recovery_ctrl_pkg.sv
// Shared types for the mispredict/halt recovery sequencer: PC type and FSM state encoding.
package recovery_ctrl_pkg;

    typedef logic [31:0] ADDR;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FLUSH    = 3'd1,
        RESTORE  = 3'd2,
        REDIRECT = 3'd3,
        HALTED   = 3'd4
    } RECOV_STATE;

endpackage

// File: rtl/recov_restore_timer.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module recov_restore_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] loadValue_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = loadValue_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/recovery_ctrl.sv
// Sequences mispredict recovery (flush, map restore, fetch redirect) and program halt.
// Optional RECOVERY_STATS_EN adds saturating mispredict and stall-cycle counters.
module recovery_ctrl
    import recovery_ctrl_pkg::*;
#(
    parameter int RESTORE_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       mispred_valid,
    input  ADDR        mispred_target,
    input  logic       halt_retired,
    output logic       rob_flush,
    output logic       BPRecoverEN,
    output logic       retire_stall,
    output logic       dispatch_stall,
    output logic       fetch_redirect_valid,
    output ADDR        fetch_redirect_pc,
    input  logic       fetch_redirect_ready,
    output logic       halted,
    output RECOV_STATE state_o
`ifdef RECOVERY_STATS_EN
    ,
    output logic [31:0] mispred_count,
    output logic [31:0] stall_cycles
`endif
);

    localparam int CNT_W = $clog2(RESTORE_CYCLES + 1);

    RECOV_STATE state_q;
    RECOV_STATE state_d;
    ADDR        target_q;
    ADDR        target_d;
    logic       timerLoad;
    logic       timerDec;
    logic       timerZero;

    recov_restore_timer #(
        .CNT_W(CNT_W)
    ) restoreTimer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_i     (timerLoad),
        .loadValue_i(CNT_W'(RESTORE_CYCLES - 1)),
        .dec_i      (timerDec),
        .zero_o     (timerZero)
    );

    // Halt outranks a same-cycle mispredict: the halt is older, so the branch is squashed.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        timerLoad = 1'b0;
        timerDec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (halt_retired) begin
                    state_d = HALTED;
                end else if (mispred_valid) begin
                    target_d = mispred_target;
                    state_d  = FLUSH;
                end
            end
            FLUSH: begin
                timerLoad = 1'b1;
                state_d   = RESTORE;
            end
            RESTORE: begin
                if (timerZero) begin
                    state_d = REDIRECT;
                end else begin
                    timerDec = 1'b1;
                end
            end
            REDIRECT: begin
                if (fetch_redirect_ready) begin
                    state_d = IDLE;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    always_comb begin
        rob_flush            = 1'b0;
        BPRecoverEN          = 1'b0;
        retire_stall         = 1'b0;
        dispatch_stall       = 1'b0;
        fetch_redirect_valid = 1'b0;
        fetch_redirect_pc    = '0;
        halted               = 1'b0;
        case (state_q)
            FLUSH: begin
                rob_flush      = 1'b1;
                BPRecoverEN    = 1'b1;
                retire_stall   = 1'b1;
                dispatch_stall = 1'b1;
            end
            RESTORE: begin
                retire_stall   = 1'b1;
                dispatch_stall = 1'b1;
            end
            REDIRECT: begin
                retire_stall         = 1'b1;
                dispatch_stall       = 1'b1;
                fetch_redirect_valid = 1'b1;
                fetch_redirect_pc    = target_q;
            end
            HALTED: begin
                halted         = 1'b1;
                retire_stall   = 1'b1;
                dispatch_stall = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state_o = state_q;

`ifdef RECOVERY_STATS_EN
    logic [31:0] mispredCount_q;
    logic [31:0] stallCycles_q;
    logic        recoveryStall;

    assign recoveryStall = dispatch_stall && (state_q != HALTED);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mispredCount_q <= '0;
            stallCycles_q  <= '0;
        end else begin
            if ((state_q == IDLE) && (state_d == FLUSH) && (mispredCount_q != '1)) begin
                mispredCount_q <= mispredCount_q + 32'd1;
            end
            if (recoveryStall && (stallCycles_q != '1)) begin
                stallCycles_q <= stallCycles_q + 32'd1;
            end
        end
    end

    assign mispred_count = mispredCount_q;
    assign stall_cycles  = stallCycles_q;
`endif

endmodule

// File: doc/recovery_ctrl.md
Name: recovery_ctrl

Overview:
Sequences branch-mispredict recovery and program halt between retire, ROB, map_table, freelist, dispatch and fetch. It takes the one-cycle mispredict indication from retire and drives the flush, map/freelist restore, dispatch/retire stalls and the fetch redirect handshake as an FSM. It is the single owner of BPRecoverEN; retire no longer drives it directly.

Parameters:
RESTORE_CYCLES, 2, cycles spent in RESTORE after the flush (must be >=1) for map/freelist rebuild to settle
CNT_W, $clog2(RESTORE_CYCLES+1), width of the restore down-counter (derived, not overridden)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
mispred_valid  in  1  retire found a mispredicted branch at ROB head this cycle
mispred_target  in  ADDR  resolved correct PC for that branch
halt_retired  in  1  retire committed a halt this cycle
rob_flush  out  1  clear all ROB entries and reset head/tail (one cycle)
BPRecoverEN  out  1  map_table/freelist restore from archi_maptable (one cycle, same cycle as rob_flush)
retire_stall  out  1  retire must not commit
dispatch_stall  out  1  dispatch must not allocate ROB/freelist
fetch_redirect_valid  out  1  redirect request to fetch
fetch_redirect_pc  out  ADDR  redirect target
fetch_redirect_ready  in  1  fetch accepts the redirect
halted  out  1  sticky; core stopped
state_o  out  RECOV_STATE  current FSM state, for debug

Behaviour:
- States: IDLE, FLUSH, RESTORE, REDIRECT, HALTED. Reset (async, reset_n=0) -> IDLE, counter=0, target reg=0. All outputs are 0 during reset.
- IDLE: all outputs 0.
  - halt_retired=1 -> HALTED. Halt wins over a same-cycle mispred_valid, because the halt is older and the branch is squashed.
  - Otherwise mispred_valid=1 -> latch mispred_target, go to FLUSH.
- FLUSH (exactly 1 cycle): rob_flush=1, BPRecoverEN=1, retire_stall=1, dispatch_stall=1. Load counter=RESTORE_CYCLES-1, go to RESTORE.
- RESTORE: retire_stall=1, dispatch_stall=1. The counter decrements each cycle. When counter==0, go to REDIRECT. RESTORE therefore lasts exactly RESTORE_CYCLES cycles.
- REDIRECT: dispatch_stall=1, retire_stall=1, fetch_redirect_valid=1, fetch_redirect_pc=latched target.
  - valid/pc must hold stable until ready.
  - On valid&&ready -> IDLE next cycle; stalls drop in that IDLE cycle.
- HALTED: absorbing until reset. halted=1, retire_stall=1, dispatch_stall=1. All other outputs 0.
- Latency: mispred_valid at cycle t -> rob_flush/BPRecoverEN at t+1 -> redirect valid at t+2+RESTORE_CYCLES, at the earliest.
- Inputs outside IDLE:
  - mispred_valid is ignored in FLUSH, RESTORE, REDIRECT and HALTED. Retire is stalled then, so it is a protocol violation.
  - halt_retired is also ignored outside IDLE.
- No combinational path from any input to any output. fetch_redirect_ready affects only the next state.
- Reset mid-recovery: async reset -> IDLE immediately. A pending redirect is dropped and the latched target is cleared.

Optional Feature:
RECOVERY_STATS_EN:
- Defined: adds outputs mispred_count[31:0] and stall_cycles[31:0].
  - mispred_count increments on each IDLE->FLUSH transition.
  - stall_cycles increments every cycle dispatch_stall=1, excluding HALTED.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: these ports and registers do not exist.

Decomposition:
- Shared package (sys_defs.svh): typedef enum logic [2:0] RECOV_STATE {IDLE, FLUSH, RESTORE, REDIRECT, HALTED}, plus the existing ADDR type.
- Sub-module: recov_restore_timer, a loadable down-counter with a zero flag. It is a reusable piece; otherwise the block stays flat.

Test Plan:
1. Reset, then mispred_valid=1 with target 0x100 at t -> rob_flush=BPRecoverEN=1 at t+1 only; stalls 1 during t+1..t+3 (RESTORE_CYCLES=2); fetch_redirect_valid=1 with pc=0x100 at t+4; ready=1 at t+4 -> IDLE at t+5, all outputs 0.
2. Redirect backpressure: hold ready=0 for 5 cycles in REDIRECT -> valid stays 1 and pc stays 0x100 throughout; exits one cycle after ready=1.
3. halt_retired=1 and mispred_valid=1 in the same IDLE cycle -> HALTED; no rob_flush ever; halted stays 1 for 20 cycles; later mispred_valid is ignored.
4. mispred_valid pulsed again during RESTORE with target 0x200 -> ignored; redirect pc remains 0x100; only one flush pulse.
5. reset_n dropped asynchronously mid-RESTORE (between clock edges) -> outputs 0 immediately; after release, state_o=IDLE and no redirect issued.
6. With RECOVERY_STATS_EN, two back-to-back recoveries with ready tied to 1 -> mispred_count=2, stall_cycles=2*(1+RESTORE_CYCLES+1)=8.
